// File: rtl/stack_replay_pkg.sv
// Shared definitions for the stack replay controller.
//   state_t        : 3-bit FSM state encoding
//   DATA_WIDTH_DEF : default width of one stack entry / displayed symbol
//   CNT_W_DEF      : default width of the requested replay count
//   BLANK_SYMBOL   : value shown on play_data while nothing is displayed
package stack_replay_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CHECK = 3'd1,
    ST_POP   = 3'd2,
    ST_LOAD  = 3'd3,
    ST_SHOW  = 3'd4,
    ST_GAP   = 3'd5,
    ST_DONE  = 3'd6
  } state_t;

  localparam int DATA_WIDTH_DEF = 4;
  localparam int CNT_W_DEF      = 7;
  localparam int BLANK_SYMBOL   = 0;

endpackage : stack_replay_pkg

// File: rtl/stack_replay_ctrl_timer.sv
// replay_timer: loadable down-counter shared by the hold and gap phases.
//   clk, reset : clock, synchronous active-high reset
//   clear      : abandon any running interval (counter to 0)
//   load       : load load_val into the counter this cycle
//   load_val   : interval length in cycles (>= 1 to produce an expire)
//   expire     : high for the single cycle in which the counter holds 1,
//                i.e. the last cycle of a loaded interval
module replay_timer #(
  parameter int TIMER_W = 26
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clear,
  input  logic               load,
  input  logic [TIMER_W-1:0] load_val,
  output logic               expire
);

  logic [TIMER_W-1:0] cnt;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values, independent of process evaluation order.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  // A loaded value of N gives exactly N cycles, the last of which flags expire.
  assign expire = (cnt == TIMER_W'(1));

endmodule : replay_timer

// File: rtl/stack_replay_ctrl.sv
// stack_replay_ctrl: drains the LIFO sequence stack and replays each symbol on
// the display for HOLD_CYCLES, separated by GAP_CYCLES of blank.
//   clk, reset  : clock, synchronous active-high reset
//   start       : one-cycle replay request (ignored unless idle)
//   abort       : cancel any replay in progress, highest priority
//   count       : symbols to replay, 0 = until stack empty (sampled on start)
//   stk_pop     : one-cycle pop strobe to the stack
//   stk_q       : stack read data, valid the cycle after stk_pop
//   stk_empty   : stack empty flag
//   play_valid  : a symbol is on play_data
//   play_data   : displayed symbol, BLANK_SYMBOL when play_valid is low
//   busy        : replay in progress
//   done        : one-cycle pulse on normal completion
//   underflow   : sticky, stack ran dry before a nonzero count was reached
module stack_replay_ctrl
  import stack_replay_pkg::*;
#(
  parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
  parameter int CNT_W       = CNT_W_DEF,
  parameter int HOLD_CYCLES = 25000000,
  parameter int GAP_CYCLES  = 5000000,
  parameter int TIMER_W     = 26
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  abort,
  input  logic [CNT_W-1:0]      count,
  output logic                  stk_pop,
  input  logic [DATA_WIDTH-1:0] stk_q,
  input  logic                  stk_empty,
  output logic                  play_valid,
  output logic [DATA_WIDTH-1:0] play_data,
  output logic                  busy,
  output logic                  done,
  output logic                  underflow
);

  localparam logic [TIMER_W-1:0]    HOLD_LOAD = TIMER_W'(HOLD_CYCLES);
  localparam logic [TIMER_W-1:0]    GAP_LOAD  = TIMER_W'(GAP_CYCLES);
  localparam bit                    HAS_GAP   = (GAP_CYCLES != 0);
  localparam logic [DATA_WIDTH-1:0] BLANK     = DATA_WIDTH'(BLANK_SYMBOL);

  state_t             state;
  logic [CNT_W-1:0]   remaining;
  logic               count_limited;   // latched count was nonzero
  logic               abort_now;
  logic               last_symbol;
  logic               timer_clear;
  logic               timer_load;
  logic [TIMER_W-1:0] timer_load_val;
  logic               timer_expire;

  assign abort_now   = abort && (state != ST_IDLE);
  // The symbol on display is the final one of a bounded replay.
  assign last_symbol = count_limited && (remaining == CNT_W'(1));

  // Timer is loaded with HOLD on the way into SHOW, and with GAP on the
  // SHOW expiry that leads into GAP.
  assign timer_clear    = abort_now;
  assign timer_load     = (state == ST_LOAD) ||
                          ((state == ST_SHOW) && timer_expire && !last_symbol && HAS_GAP);
  assign timer_load_val = (state == ST_LOAD) ? HOLD_LOAD : GAP_LOAD;

  replay_timer #(
    .TIMER_W (TIMER_W)
  ) u_timer (
    .clk      (clk),
    .reset    (reset),
    .clear    (timer_clear),
    .load     (timer_load),
    .load_val (timer_load_val),
    .expire   (timer_expire)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= ST_IDLE;
      remaining     <= '0;
      count_limited <= 1'b0;
      stk_pop       <= 1'b0;
      play_valid    <= 1'b0;
      play_data     <= BLANK;
      busy          <= 1'b0;
      done          <= 1'b0;
      underflow     <= 1'b0;
    end else begin
      // Strobes default low so each lasts exactly one cycle.
      stk_pop <= 1'b0;
      done    <= 1'b0;

      if (abort_now) begin
        // A pop already on the bus this cycle still happens; its data is
        // simply never captured.
        state      <= ST_IDLE;
        play_valid <= 1'b0;
        play_data  <= BLANK;
        busy       <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (start && !abort) begin
              remaining     <= count;
              count_limited <= (count != '0);
              underflow     <= 1'b0;
              busy          <= 1'b1;
              state         <= ST_CHECK;
            end
          end

          ST_CHECK: begin
            if (stk_empty) begin
              if (count_limited) begin
                underflow <= 1'b1;
              end
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= ST_DONE;
            end else begin
              stk_pop <= 1'b1;
              state   <= ST_POP;
            end
          end

          ST_POP: begin
            state <= ST_LOAD;
          end

          ST_LOAD: begin
            // The stack registers its output on the pop edge, so stk_q is
            // stable here.
            play_data  <= stk_q;
            play_valid <= 1'b1;
            state      <= ST_SHOW;
          end

          ST_SHOW: begin
            if (timer_expire) begin
              play_valid <= 1'b0;
              play_data  <= BLANK;
              if (count_limited) begin
                remaining <= remaining - 1'b1;
              end
              if (last_symbol) begin
                busy  <= 1'b0;
                done  <= 1'b1;
                state <= ST_DONE;
              end else if (!HAS_GAP) begin
                state <= ST_CHECK;
              end else begin
                state <= ST_GAP;
              end
            end
          end

          ST_GAP: begin
            if (timer_expire) begin
              state <= ST_CHECK;
            end
          end

          ST_DONE: begin
            state <= ST_IDLE;
          end

          default: begin
            state <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule : stack_replay_ctrl

// File: tb/tb_stack_replay_ctrl.sv
// Directed testbench for stack_replay_ctrl with HOLD=3, GAP=2 and a small LIFO
// stack model whose read data is registered on the pop edge. Every cycle of a
// replay is compared against a hand-derived schedule:
//   pop of symbol i    : cycle 2 + P*i
//   symbol i visible   : cycles 4 + P*i .. 3 + H + P*i
// where cycle 0 is the start cycle and P = H + G + 3.
module tb_stack_replay_ctrl;

  localparam int H = 3;
  localparam int G = 2;
  localparam int P = H + G + 3;
  localparam int NEVER = 999;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       abort;
  logic [6:0] count;
  logic       stk_pop;
  logic [3:0] stk_q = '0;
  logic       stk_empty;
  logic       play_valid;
  logic [3:0] play_data;
  logic       busy;
  logic       done;
  logic       underflow;

  // Stack model controls
  logic       push;
  logic [3:0] push_data;
  logic       stk_clear;
  logic [3:0] mem [0:7];
  logic [3:0] sp = '0;
  int         pop_underrun = 0;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  stack_replay_ctrl #(
    .DATA_WIDTH  (4),
    .CNT_W       (7),
    .HOLD_CYCLES (H),
    .GAP_CYCLES  (G),
    .TIMER_W     (26)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .abort      (abort),
    .count      (count),
    .stk_pop    (stk_pop),
    .stk_q      (stk_q),
    .stk_empty  (stk_empty),
    .play_valid (play_valid),
    .play_data  (play_data),
    .busy       (busy),
    .done       (done),
    .underflow  (underflow)
  );

  assign stk_empty = (sp == 4'd0);

  always @(posedge clk) begin
    if (stk_clear) begin
      sp <= '0;
    end else begin
      if (push) begin
        mem[sp[2:0]] <= push_data;
        sp           <= sp + 4'd1;
      end
      if (stk_pop) begin
        if (sp != 4'd0) begin
          stk_q <= mem[sp[2:0] - 3'd1];
          sp    <= sp - 4'd1;
        end else begin
          pop_underrun <= pop_underrun + 1;
        end
      end
    end
  end

  // {underflow, busy, done, stk_pop, play_valid, play_data}
  function automatic logic [8:0] obs();
    return {underflow, busy, done, stk_pop, play_valid, play_data};
  endfunction

  // Expected output vector for cycle cyc of a replay of nsym symbols
  // (s0 popped first).
  function automatic logic [8:0] exp_vec(input int cyc, input int nsym,
                                         input logic [3:0] s0, input logic [3:0] s1,
                                         input logic [3:0] s2, input int done_cyc,
                                         input int busy_end, input int uf_from);
    logic       v;
    logic       p;
    logic [3:0] d;
    v = 1'b0;
    p = 1'b0;
    d = 4'd0;
    for (int i = 0; i < nsym; i++) begin
      if (cyc == 2 + P * i) p = 1'b1;
      if (cyc >= 4 + P * i && cyc <= 3 + H + P * i) begin
        v = 1'b1;
        d = (i == 0) ? s0 : (i == 1) ? s1 : s2;
      end
    end
    return {(cyc >= uf_from), (cyc >= 1 && cyc <= busy_end), (cyc == done_cyc), p, v, d};
  endfunction

  // All helpers are entered and left just after a falling edge.
  task automatic push_sym(input logic [3:0] v);
    push      = 1'b1;
    push_data = v;
    @(negedge clk);
    push      = 1'b0;
  endtask

  task automatic clear_stack();
    stk_clear = 1'b1;
    @(negedge clk);
    stk_clear = 1'b0;
  endtask

  task automatic test_reset();
    logic [8:0] a;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    a = obs();
    n_checks++;
    if (a !== 9'd0) begin
      n_errors++;
      $display("FAIL reset_state: got %b expected %b", a, 9'd0);
    end
    reset = 1'b0;
    @(negedge clk);
    a = obs();
    n_checks++;
    if (a !== 9'd0) begin
      n_errors++;
      $display("FAIL idle_after_reset: got %b expected %b", a, 9'd0);
    end
  endtask

  task automatic test_drain_all();
    logic [8:0] a, e;
    int pops;
    pops = 0;
    clear_stack();
    push_sym(4'd5);
    push_sym(4'd9);
    push_sym(4'd2);
    count = 7'd0;
    start = 1'b1;
    for (int cyc = 1; cyc <= 30; cyc++) begin
      @(negedge clk);
      start = 1'b0;
      a = obs();
      e = exp_vec(cyc, 3, 4'd2, 4'd9, 4'd5, 26, 25, NEVER);
      pops += int'(stk_pop);
      n_checks++;
      if (a !== e) begin
        n_errors++;
        $display("FAIL drain_all cyc %0d: got %b expected %b", cyc, a, e);
      end
    end
    n_checks++;
    if (pops != 3) begin
      n_errors++;
      $display("FAIL drain_all_pops: got %0d expected 3", pops);
    end
    n_checks++;
    if (sp !== 4'd0) begin
      n_errors++;
      $display("FAIL drain_all_depth: got %0d expected 0", sp);
    end
  endtask

  task automatic test_count_limit();
    logic [8:0] a, e;
    clear_stack();
    push_sym(4'd1);
    push_sym(4'd3);
    push_sym(4'd6);
    push_sym(4'd8);
    count = 7'd2;
    start = 1'b1;
    for (int cyc = 1; cyc <= 18; cyc++) begin
      @(negedge clk);
      start = 1'b0;
      a = obs();
      e = exp_vec(cyc, 2, 4'd8, 4'd6, 4'd0, 15, 14, NEVER);
      n_checks++;
      if (a !== e) begin
        n_errors++;
        $display("FAIL count_limit cyc %0d: got %b expected %b", cyc, a, e);
      end
    end
    n_checks++;
    if (sp !== 4'd2) begin
      n_errors++;
      $display("FAIL count_limit_depth: got %0d expected 2", sp);
    end
  endtask

  task automatic test_underflow();
    logic [8:0] a, e;
    clear_stack();
    push_sym(4'd7);
    count = 7'd3;
    start = 1'b1;
    for (int cyc = 1; cyc <= 16; cyc++) begin
      @(negedge clk);
      start = 1'b0;
      a = obs();
      e = exp_vec(cyc, 1, 4'd7, 4'd0, 4'd0, 10, 9, 10);
      n_checks++;
      if (a !== e) begin
        n_errors++;
        $display("FAIL underflow cyc %0d: got %b expected %b", cyc, a, e);
      end
    end
  endtask

  // Runs straight after test_underflow: underflow must still be set, then
  // clear on the new start.
  task automatic test_empty_start();
    logic [8:0] a, e;
    clear_stack();
    n_checks++;
    if (underflow !== 1'b1) begin
      n_errors++;
      $display("FAIL underflow_sticky: got %b expected 1", underflow);
    end
    count = 7'd0;
    start = 1'b1;
    for (int cyc = 1; cyc <= 6; cyc++) begin
      @(negedge clk);
      start = 1'b0;
      a = obs();
      e = exp_vec(cyc, 0, 4'd0, 4'd0, 4'd0, 2, 1, NEVER);
      n_checks++;
      if (a !== e) begin
        n_errors++;
        $display("FAIL empty_start cyc %0d: got %b expected %b", cyc, a, e);
      end
    end
  endtask

  task automatic test_abort();
    logic [8:0] a, e;
    clear_stack();
    push_sym(4'd1);
    push_sym(4'd2);
    push_sym(4'd3);
    count = 7'd0;
    start = 1'b1;
    // Abort sampled at the end of cycle 13, the middle of the second SHOW.
    for (int cyc = 1; cyc <= 30; cyc++) begin
      @(negedge clk);
      start = 1'b0;
      a = obs();
      e = (cyc >= 14) ? 9'd0 : exp_vec(cyc, 2, 4'd3, 4'd2, 4'd0, NEVER, 13, NEVER);
      n_checks++;
      if (a !== e) begin
        n_errors++;
        $display("FAIL abort cyc %0d: got %b expected %b", cyc, a, e);
      end
      abort = (cyc == 13);
    end
    n_checks++;
    if (sp !== 4'd1) begin
      n_errors++;
      $display("FAIL abort_depth: got %0d expected 1", sp);
    end
    // Remaining entry replays normally.
    count = 7'd1;
    start = 1'b1;
    for (int cyc = 1; cyc <= 10; cyc++) begin
      @(negedge clk);
      start = 1'b0;
      a = obs();
      e = exp_vec(cyc, 1, 4'd1, 4'd0, 4'd0, 7, 6, NEVER);
      n_checks++;
      if (a !== e) begin
        n_errors++;
        $display("FAIL after_abort cyc %0d: got %b expected %b", cyc, a, e);
      end
    end
  endtask

  task automatic test_start_while_busy();
    logic [8:0] a, e;
    clear_stack();
    push_sym(4'd3);
    push_sym(4'd4);
    push_sym(4'd5);
    count = 7'd2;
    start = 1'b1;
    for (int cyc = 1; cyc <= 20; cyc++) begin
      @(negedge clk);
      start = 1'b0;
      a = obs();
      e = exp_vec(cyc, 2, 4'd5, 4'd4, 4'd0, 15, 14, NEVER);
      n_checks++;
      if (a !== e) begin
        n_errors++;
        $display("FAIL busy_start cyc %0d: got %b expected %b", cyc, a, e);
      end
      // A second request with count=0 mid-replay must be ignored.
      if (cyc == 5) begin
        start = 1'b1;
        count = 7'd0;
      end
    end
    n_checks++;
    if (sp !== 4'd1) begin
      n_errors++;
      $display("FAIL busy_start_depth: got %0d expected 1", sp);
    end
  endtask

  task automatic test_reset_mid_gap();
    logic [8:0] a, e;
    clear_stack();
    push_sym(4'd6);
    push_sym(4'd7);
    count = 7'd0;
    start = 1'b1;
    // Reset sampled at the end of cycle 7, the first GAP cycle.
    for (int cyc = 1; cyc <= 20; cyc++) begin
      @(negedge clk);
      start = 1'b0;
      a = obs();
      e = (cyc >= 8) ? 9'd0 : exp_vec(cyc, 2, 4'd7, 4'd6, 4'd0, NEVER, NEVER, NEVER);
      n_checks++;
      if (a !== e) begin
        n_errors++;
        $display("FAIL reset_mid_gap cyc %0d: got %b expected %b", cyc, a, e);
      end
      reset = (cyc == 7);
    end
    n_checks++;
    if (sp !== 4'd1) begin
      n_errors++;
      $display("FAIL reset_mid_gap_depth: got %0d expected 1", sp);
    end
  endtask

  initial begin
    reset     = 1'b1;
    start     = 1'b0;
    abort     = 1'b0;
    count     = '0;
    push      = 1'b0;
    push_data = '0;
    stk_clear = 1'b1;
    @(negedge clk);
    stk_clear = 1'b0;

    test_reset();
    test_drain_all();
    test_count_limit();
    test_underflow();
    test_empty_start();
    test_abort();
    test_start_while_busy();
    test_reset_mid_gap();

    n_checks++;
    if (pop_underrun != 0) begin
      n_errors++;
      $display("FAIL pop_on_empty: got %0d expected 0", pop_underrun);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_stack_replay_ctrl

// File: doc/stack_replay_ctrl.md
Name: stack_replay_ctrl

Overview:
- Read-side controller for the game's LIFO sequence stack: after a start command it pops stored symbols (spell/colour codes) one at a time and presents each on a timed display output.
- Each symbol is held for a fixed on-time, followed by a blank gap.
- Sits between the stack and the LED/hex display driver; the player-input path pushes, this block drains and replays.

Parameters:
- DATA_WIDTH, 4, width of one stack entry and of play_data
- CNT_W, 7, width of the requested replay count
- HOLD_CYCLES, 25000000, clk cycles each symbol is shown (must be >= 1)
- GAP_CYCLES, 5000000, blank clk cycles between symbols (0 allowed = no gap)
- TIMER_W, 26, timer width; must hold max(HOLD_CYCLES, GAP_CYCLES)

Ports:
- clk  in  1  system clock
- reset  in  1  reset, synchronous, active-high
- start  in  1  one-cycle request to begin a replay; ignored while busy
- abort  in  1  cancel replay; takes priority over start and all other activity
- count  in  CNT_W  number of symbols to replay, sampled on accepted start; 0 = replay until stack empty
- stk_pop  out  1  single-cycle pop strobe to the stack
- stk_q  in  DATA_WIDTH  stack read data, registered by the stack on the pop edge
- stk_empty  in  1  stack empty flag
- play_valid  out  1  high while play_data shows a symbol
- play_data  out  DATA_WIDTH  symbol being displayed; 0 when play_valid low
- busy  out  1  high from the cycle after an accepted start until the cycle DONE is entered
- done  out  1  one-cycle pulse when a replay completes normally
- underflow  out  1  sticky: stack emptied before a nonzero count was reached; cleared on next accepted start or reset

Behaviour:
- Reset: state IDLE; stk_pop=0, play_valid=0, play_data=0, busy=0, done=0, underflow=0; timers and counters cleared. Reset mid-replay abandons it with no done pulse and no further pops.
- FSM states: IDLE, CHECK, POP, LOAD, SHOW, GAP, DONE.
- IDLE: start=1 and abort=0 -> latch count into remaining, clear underflow, go to CHECK.
- CHECK: stk_empty=1 -> if latched count != 0, set underflow. Go to DONE.
- CHECK: otherwise go to POP.
- POP: stk_pop=1 for exactly this one cycle, then go to LOAD.
- LOAD: capture stk_q into play_data; it is valid one cycle after the pop strobe. Set play_valid=1, load the timer with HOLD_CYCLES, go to SHOW.
- SHOW: decrement the timer. On expiry, drop play_valid, set play_data=0 and decrement remaining (if count != 0).
  - remaining reached 0 (nonzero count) -> DONE.
  - GAP_CYCLES=0 -> CHECK.
  - otherwise load GAP_CYCLES and go to GAP.
- GAP: on timer expiry -> CHECK.
- DONE: done=1 for one cycle, busy=0, go to IDLE.
- Cycle counts:
  - First symbol: play_valid rises 4 cycles after the start cycle (CHECK, POP, LOAD, then visible). It stays high exactly HOLD_CYCLES cycles.
  - Symbol-to-symbol period: HOLD_CYCLES + GAP_CYCLES + 3 cycles.
- abort in any non-IDLE state: next cycle IDLE, play_valid=0, play_data=0, busy=0. No done pulse; underflow unchanged. An abort in the same cycle as POP still lets that pop occur; the popped data is discarded.
- start while not IDLE is ignored; count is not re-sampled.
- stk_pop is never asserted while stk_empty=1 as sampled in CHECK, so the stack pointer never wraps below zero.
- stk_push is not driven by this block. The top level guarantees no pushes while busy=1.
- remaining is CNT_W bits and never decrements below 0.

Decomposition:
- Shared package stack_replay_pkg:
  - state encoding constants (3-bit)
  - DATA_WIDTH/CNT_W defaults
  - the blank symbol value (0)
- One natural sub-module, replay_timer: loadable TIMER_W down-counter with a load input and a one-cycle expire pulse. Used for both HOLD and GAP.

Test Plan (HOLD_CYCLES=3, GAP_CYCLES=2, stack model with registered q):
- Stack holds 5,9,2 (2 on top), count=0, start pulse:
  - required: play_data shows 2, 9, 5, each with play_valid high exactly 3 cycles and a 2-cycle blank between symbols
  - required: first play_valid rises 4 cycles after start
  - required: done pulses once, underflow=0, exactly 3 stk_pop pulses
- Stack holds 4 entries, count=2:
  - required: exactly 2 pops, top two symbols shown, done pulse
  - required: 2 entries remain in the stack, underflow=0
- Stack holds 1 entry, count=3:
  - required: one symbol shown, then done
  - required: underflow=1 and it stays 1 until the next start
- Empty stack, start with count=0:
  - required: done pulses 2 cycles after start, no stk_pop, underflow=0
- abort asserted during the second SHOW:
  - required: next cycle play_valid=0, busy=0; no done pulse and no further pops
  - then: a start with the new stack top replays normally
- reset asserted during GAP, and start pulsed while busy:
  - required: reset returns all outputs to reset values in 1 cycle
  - required: a mid-replay start changes neither the sequence nor count
